key_debounce: RTL
=================

// Module: key_debounce
// PURPOSE
//  Front-end for one board push-button (active-low, idle-high) feeding the LED control logic.
//  Synchronises the raw pin and debounces it with a 4-state FSM.
//  Emits clean single-cycle press, release and long-press pulses plus a debounced level.
//  Consumers use the pulses to step or redirect LED flow patterns.
// PARAMETERS
//  CNT_MAX   20'd999_999     debounce window, clock cycles (20 ms @ 50 MHz); legal 1..2^20-1
//  LONG_MAX  26'd49_999_999  long-press threshold, cycles in HELD (1 s @ 50 MHz); legal 1..2^26-1
// PORTS
//  sys_clk      in   1  system clock, 50 MHz
//  sys_rst_n    in   1  global reset, asynchronous, active-low
//  key_in       in   1  raw button pin, asynchronous, 0 = pressed
//  key_press    out  1  one-cycle pulse: debounced press accepted
//  key_release  out  1  one-cycle pulse: debounced release accepted
//  key_long     out  1  one-cycle pulse: held for LONG_MAX cycles
//  key_level    out  1  debounced state, 1 = pressed
// BEHAVIOUR
//  Reset (async, sys_rst_n low): sync flops <= 1, state <= IDLE, debounce cnt <= 0,
//   long cnt <= 0, long_done <= 0, all outputs <= 0. Takes effect immediately, any state.
//  Sync: 2-flop chain key_in -> s1 -> s2; key_sync = s2. FSM only ever reads key_sync.
//  States: IDLE (released), PRESS_FILT, HELD (pressed), RELEASE_FILT.
//   IDLE: key_sync==0 -> PRESS_FILT, cnt <= 0.
//   PRESS_FILT: key_sync==1 -> IDLE, cnt <= 0 (bounce rejected, no pulse).
//     key_sync==0 and cnt==CNT_MAX -> HELD, key_press <= 1, cnt <= 0, long cnt <= 0, long_done <= 0.
//     else cnt <= cnt + 1.
//   HELD: key_sync==1 -> RELEASE_FILT, cnt <= 0. Else long cnt advances (see below).
//   RELEASE_FILT: key_sync==0 -> HELD, cnt <= 0 (bounce); long cnt and long_done hold.
//     key_sync==1 and cnt==CNT_MAX -> IDLE, key_release <= 1, cnt <= 0.
//     else cnt <= cnt + 1.
//  Latency: key_in low sampled at edge E0 and held -> key_press high for exactly the one cycle
//   after edge E0+CNT_MAX+3. Release is symmetric: key_release high after E0+CNT_MAX+3.
//  Long press: in HELD with long_done==0, long cnt increments each cycle. When long cnt==LONG_MAX:
//   key_long <= 1 (one cycle), long_done <= 1, long cnt stops. Max one key_long per press.
//   long_done clears only on the next accepted press. Time spent in RELEASE_FILT does not count.
//  key_level = 1 in HELD and RELEASE_FILT, 0 in IDLE and PRESS_FILT. Registered.
//  Pulses are registered and default to 0 every cycle. key_press/key_release never coincide.
//   key_long may coincide only with HELD, never with key_press in the same cycle.
//  Widths: cnt 20 bit, long cnt 26 bit. No wrap: compare uses ==, cleared on every state change.
// TESTING (bench overrides CNT_MAX=4, LONG_MAX=10)
//  1 Clean press: key_in 1->0 at edge E0, held -> key_press high after E7 only; key_level 1 from E7.
//  2 Bounce: key_in low for 3 cycles then high, repeated 5x, then held low -> no pulse during
//     bounce; exactly one key_press, 8 cycles after the last falling edge.
//  3 Release: from HELD, key_in 0->1 at E0, held -> key_release after E7; key_level 0 from E7.
//  4 Long: hold pressed -> key_long once, 11 cycles after key_press; keep holding 50 more
//     cycles -> no further key_long; release/re-press -> key_long can fire again.
//  5 Release glitch: in HELD, key_in high for 2 cycles -> no key_release; long count resumes;
//     key_long is delayed by the cycles spent in RELEASE_FILT.
//  6 Reset mid-filter: assert sys_rst_n low during PRESS_FILT -> outputs 0 immediately;
//     after deassert with key_in held low -> key_press 8 cycles after the first sampling edge.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button front end: two-flop synchroniser plus a 4-state debounce FSM that
// produces registered press/release/long-press pulses and a debounced level.
module key_debounce #(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_level
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        HELD,
        RELEASE_FILT
    } state_t;

    state_t      state;
    logic        s1;
    logic        s2;
    logic        key_sync;
    logic [19:0] cnt;
    logic [25:0] long_cnt;
    logic        long_done;

    // Sync flops reset to 1 so an idle (high) pin never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    assign key_sync = s2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            long_cnt    <= '0;
            long_done   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_level   <= 1'b0;
        end else begin
            // NOTE: pulses default low here and are overridden below; with
            // non-blocking assignments the last write in the block wins.
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_sync) begin
                        state <= PRESS_FILT;
                        cnt   <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (key_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state     <= HELD;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                        cnt       <= '0;
                        long_cnt  <= '0;
                        long_done <= 1'b0;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                HELD: begin
                    if (key_sync) begin
                        state <= RELEASE_FILT;
                        cnt   <= '0;
                    end else if (!long_done) begin
                        if (long_cnt == LONG_MAX) begin
                            key_long  <= 1'b1;
                            long_done <= 1'b1;
                        end else begin
                            long_cnt <= long_cnt + 26'd1;
                        end
                    end
                end
                RELEASE_FILT: begin
                    // long_cnt/long_done hold here so a glitch only pauses the long timer.
                    if (!key_sync) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state       <= IDLE;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
